// File: rtl/ahmes_alu_pkg.sv
// Shared definitions for the Ahmes ALU: data width, opcode encoding, flag bundle.
package ahmes_alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_TRF  = 4'b0000,
        OP_ADIC = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_OU   = 4'b0011,
        OP_E    = 4'b0100,
        OP_NAO  = 4'b0101,
        OP_DLE  = 4'b0110,
        OP_DLD  = 4'b0111,
        OP_DAE  = 4'b1000,
        OP_DAD  = 4'b1001
    } opcode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic b;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/ahmes_alu_core.sv
// Combinational part of the Ahmes ALU: opcode decode, next result and flags.
module ahmes_alu_core
    import ahmes_alu_pkg::*;
(
    input  logic [3:0]        operacao,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] r,
    output alu_flags_t        flags
);

    // 9-bit sum and difference; bit 8 is carry out / borrow (A < B unsigned).
    logic [DATA_W:0] sum9;
    logic [DATA_W:0] diff9;

    assign sum9  = {1'b0, a} + {1'b0, b};
    assign diff9 = {1'b0, a} - {1'b0, b};

    // Select result and C/B/V per opcode; N and Z always follow the result.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        r       = b;
        flags   = '0;
        case (operacao)
            OP_ADIC: begin
                r       = sum9[DATA_W-1:0];
                flags.c = sum9[DATA_W];
                flags.v = (a[7] == b[7]) && (sum9[7] != a[7]);
            end
            OP_SUB: begin
                r       = diff9[DATA_W-1:0];
                flags.b = diff9[DATA_W];
                flags.v = (a[7] != b[7]) && (diff9[7] != a[7]);
            end
            OP_OU:  r = a | b;
            OP_E:   r = a & b;
            OP_NAO: r = ~a;
            OP_DLE: begin
                r       = {a[6:0], cin};
                flags.c = a[7];
            end
            OP_DLD: begin
                r       = {cin, a[7:1]};
                flags.c = a[0];
            end
            OP_DAE: begin
                r       = {a[6:0], 1'b0};
                flags.c = a[7];
            end
            OP_DAD: begin
                r       = {1'b0, a[7:1]};
                flags.c = a[0];
            end
            default: r = b;   // OP_TRF and unused encodings transfer operand B
        endcase
        flags.n = r[7];
        flags.z = (r == '0);
    end

endmodule

// File: rtl/ahmes_alu.sv
// Ahmes ALU top: registers the core's result and flags, one cycle of latency.
module ahmes_alu
    import ahmes_alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        operacao,
    input  logic [DATA_W-1:0] operA,
    input  logic [DATA_W-1:0] operB,
    input  logic              Cin,
    output logic [DATA_W-1:0] result,
    output logic              N,
    output logic              Z,
    output logic              C,
    output logic              B,
    output logic              V
);

    logic [DATA_W-1:0] next_r;
    alu_flags_t        next_flags;
    alu_flags_t        flags_q;

    ahmes_alu_core u_core (
        .operacao (operacao),
        .a        (operA),
        .b        (operB),
        .cin      (Cin),
        .r        (next_r),
        .flags    (next_flags)
    );

    // Output register; reset clears result and flags and wins over any operation.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all regs update together at the edge.
        if (rst) begin
            result  <= '0;
            flags_q <= '0;
        end else begin
            result  <= next_r;
            flags_q <= next_flags;
        end
    end

    assign N = flags_q.n;
    assign Z = flags_q.z;
    assign C = flags_q.c;
    assign B = flags_q.b;
    assign V = flags_q.v;

endmodule

// File: tb/tb_ahmes_alu.sv
// Self-checking bench for ahmes_alu: directed vector table plus reset,
// back-to-back and input-hold sequences. Compares {result, N,Z,C,B,V}.
module tb_ahmes_alu;
    import ahmes_alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] operacao;
    logic [7:0] operA;
    logic [7:0] operB;
    logic       Cin;
    logic [7:0] result;
    logic       N, Z, C, B, V;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] r;
        logic [4:0] nzcbv;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    ahmes_alu dut (
        .clk      (clk),
        .rst      (rst),
        .operacao (operacao),
        .operA    (operA),
        .operB    (operB),
        .Cin      (Cin),
        .result   (result),
        .N        (N),
        .Z        (Z),
        .C        (C),
        .B        (B),
        .V        (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] exp_r, input logic [4:0] exp_f);
        logic [12:0] got;
        logic [12:0] exp;
        got = {result, N, Z, C, B, V};
        exp = {exp_r, exp_f};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got r=%0d nzcbv=%05b, want r=%0d nzcbv=%05b",
                     name, got[12:5], got[4:0], exp_r, exp_f);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        operacao = op;
        operA    = a;
        operB    = b;
        Cin      = cin;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 op       a     b    cin  r     nzcbv
        vecs[0]  = '{OP_ADIC, 8'd10,  8'd20,  1'b0, 8'd30,  5'b00000};
        vecs[1]  = '{OP_ADIC, 8'd127, 8'd1,   1'b0, 8'd128, 5'b10001};
        vecs[2]  = '{OP_ADIC, 8'd255, 8'd1,   1'b1, 8'd0,   5'b01100};
        vecs[3]  = '{OP_ADIC, 8'h80,  8'h80,  1'b0, 8'd0,   5'b01101};
        vecs[4]  = '{OP_SUB,  8'd50,  8'd20,  1'b0, 8'd30,  5'b00000};
        vecs[5]  = '{OP_SUB,  8'd0,   8'd1,   1'b0, 8'd255, 5'b10010};
        vecs[6]  = '{OP_SUB,  8'd128, 8'd1,   1'b0, 8'd127, 5'b00001};
        vecs[7]  = '{OP_SUB,  8'd20,  8'd50,  1'b0, 8'hE2,  5'b10010};
        vecs[8]  = '{OP_OU,   8'd170, 8'd85,  1'b0, 8'd255, 5'b10000};
        vecs[9]  = '{OP_E,    8'd240, 8'd15,  1'b0, 8'd0,   5'b01000};
        vecs[10] = '{OP_NAO,  8'd240, 8'h33,  1'b1, 8'd15,  5'b00000};
        vecs[11] = '{OP_DLE,  8'd129, 8'd0,   1'b1, 8'd3,   5'b00100};
        vecs[12] = '{OP_DLD,  8'd129, 8'd0,   1'b1, 8'd192, 5'b10100};
        vecs[13] = '{OP_DAE,  8'd129, 8'd0,   1'b1, 8'd2,   5'b00100};
        vecs[14] = '{OP_DAD,  8'd129, 8'd0,   1'b1, 8'd64,  5'b00100};
        vecs[15] = '{OP_DLE,  8'd129, 8'd0,   1'b0, 8'd2,   5'b00100};
        vecs[16] = '{OP_DLD,  8'h02,  8'd0,   1'b0, 8'd1,   5'b00000};
        vecs[17] = '{OP_TRF,  8'h11,  8'h80,  1'b1, 8'h80,  5'b10000};
        vecs[18] = '{4'b1010, 8'hFF,  8'h00,  1'b0, 8'h00,  5'b01000};
        vecs[19] = '{4'b1111, 8'h01,  8'h5A,  1'b0, 8'h5A,  5'b00000};

        // Reset held two cycles with an ADIC 255+1 pending on the inputs.
        rst = 1'b1;
        drive(OP_ADIC, 8'd255, 8'd1, 1'b0);
        step();
        check("reset_edge1", 8'd0, 5'b00000);
        step();
        check("reset_edge2", 8'd0, 5'b00000);
        rst = 1'b0;
        step();
        check("post_reset_adic", 8'd0, 5'b01100);

        // Directed vector table, one operation per cycle.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            step();
            check($sformatf("vec%0d", i), vecs[i].r, vecs[i].nzcbv);
        end

        // Back-to-back ADIC, SUB, NAO: each result appears exactly one edge later.
        drive(OP_ADIC, 8'd1, 8'd2, 1'b0);
        step();
        check("b2b_adic", 8'd3, 5'b00000);
        drive(OP_SUB, 8'd9, 8'd4, 1'b0);
        step();
        check("b2b_sub", 8'd5, 5'b00000);
        drive(OP_NAO, 8'h0F, 8'd0, 1'b0);
        step();
        check("b2b_nao", 8'hF0, 5'b10000);

        // Inputs changed between edges must not disturb the registered outputs.
        drive(OP_SUB, 8'd0, 8'd1, 1'b0);
        #2;
        check("hold_between_edges", 8'hF0, 5'b10000);
        step();
        check("hold_then_sub", 8'd255, 5'b10010);

        // Reset asserted mid-stream takes priority over the operation.
        rst = 1'b1;
        drive(OP_OU, 8'd170, 8'd85, 1'b0);
        step();
        check("reset_priority", 8'd0, 5'b00000);
        rst = 1'b0;
        step();
        check("after_reset_ou", 8'd255, 5'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
